// File: rtl/servo_pwm_pkg.sv
// ---------------------------------------------------------------------------
// servo_pwm_pkg
// Shared helpers for the servo PWM bank and its timebase:
//   addr_width   - index width for n entries, never narrower than one bit
//   cnt_width    - frame counter width, one bit wider than the largest count
//                  so "count < min_pulse + duty" never overflows
//   params_legal - parameter sanity check used at elaboration time
// ---------------------------------------------------------------------------
package servo_pwm_pkg;

    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int period);
        return $clog2(period) + 1;
    endfunction

    // The frame must be long enough that the widest pulse (min_pulse plus
    // the largest duty code) still ends before the frame wraps, otherwise
    // the output would stay high across the frame boundary.
    function automatic bit params_legal(input int num_ch,
                                        input int duty_w,
                                        input int prescale,
                                        input int min_pulse,
                                        input int period_ticks,
                                        input int reset_duty,
                                        input int aw);
        bit ok;
        ok = 1'b1;
        if (num_ch < 1 || num_ch > 64)                       ok = 1'b0;
        if (duty_w < 1 || duty_w > 16)                       ok = 1'b0;
        if (prescale < 1)                                    ok = 1'b0;
        if (min_pulse < 0)                                   ok = 1'b0;
        if (period_ticks <= min_pulse + (1 << duty_w) - 1)   ok = 1'b0;
        if (reset_duty < 0 || reset_duty >= (1 << duty_w))   ok = 1'b0;
        if (aw < addr_width(num_ch))                         ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/servo_pwm_timebase.sv
// ---------------------------------------------------------------------------
// servo_pwm_timebase
// Shared PWM timebase: a prescaler producing one duty tick every PRESCALE
// clocks, and a frame counter stepping on that tick over 0..PERIOD_TICKS-1.
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   tick        out  high on the last prescaler cycle of each tick
//   wrap        out  high on the cycle that ends the frame (commit point)
//   cnt         out  current tick index within the frame
//   frame_start out  registered pulse on the cycle after wrap
// ---------------------------------------------------------------------------
module servo_pwm_timebase
    import servo_pwm_pkg::*;
#(
    parameter  int PRESCALE     = 196,
    parameter  int PERIOD_TICKS = 5102,
    localparam int CW           = cnt_width(PERIOD_TICKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          tick,
    output logic          wrap,
    output logic [CW-1:0] cnt,
    output logic          frame_start
);

    localparam int PW = addr_width(PRESCALE);

    logic [PW-1:0] pre_cnt;

    // With PRESCALE=1 the prescaler stays at zero and tick is always high.
    assign tick = (pre_cnt == PW'(PRESCALE - 1));
    assign wrap = tick && (cnt == CW'(PERIOD_TICKS - 1));

    // Prescaler and frame counter advance together; reset restarts the
    // frame at tick 0 so a mid-frame reset never yields a truncated frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                cnt <= wrap ? '0 : cnt + CW'(1);
            end
            frame_start <= wrap;
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// ---------------------------------------------------------------------------
// servo_pwm_bank
// N-channel servo PWM bank with a double-buffered duty register file.
// Writes land in the shadow bank at any time; the whole shadow bank is copied
// into the active bank at the frame wrap, so every pulse uses one duty value.
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   wr_en       in   single-cycle write strobe
//   wr_addr     in   channel index to write
//   wr_data     in   duty value to write
//   wr_err      out  registered pulse, write addressed a missing channel
//   rd_addr     in   readback index
//   rd_data     out  shadow[rd_addr] (combinational), 0 when out of range
//   out_en      in   global output enable
//   frame_start out  registered pulse on the cycle after the commit
//   pwm_out     out  registered pulse outputs, one per channel
// ---------------------------------------------------------------------------
module servo_pwm_bank
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int DUTY_W       = 8,
    parameter int PRESCALE     = 196,
    parameter int MIN_PULSE    = 255,
    parameter int PERIOD_TICKS = 5102,
    parameter int RESET_DUTY   = 2 ** (DUTY_W - 1),
    // The address bus may be wider than the bank needs so an upstream
    // decoder can present addresses past the last channel and see wr_err.
    parameter int AW           = addr_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DUTY_W-1:0] wr_data,
    output logic              wr_err,
    input  logic [AW-1:0]     rd_addr,
    output logic [DUTY_W-1:0] rd_data,
    input  logic              out_en,
    output logic              frame_start,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int CW  = cnt_width(PERIOD_TICKS);
    localparam int AW1 = AW + 1;

    if (!params_legal(NUM_CH, DUTY_W, PRESCALE, MIN_PULSE, PERIOD_TICKS,
                      RESET_DUTY, AW)) begin : g_bad_params
        $fatal(1, "servo_pwm_bank: illegal parameter combination");
    end

    logic [DUTY_W-1:0] shadow [NUM_CH];
    logic [DUTY_W-1:0] active [NUM_CH];
    logic [NUM_CH-1:0] pwm_next;
    logic [CW-1:0]     cnt;
    logic              tick;
    logic              wrap;
    logic              wr_in_range;

    servo_pwm_timebase #(
        .PRESCALE    (PRESCALE),
        .PERIOD_TICKS(PERIOD_TICKS)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .wrap       (wrap),
        .cnt        (cnt),
        .frame_start(frame_start)
    );

    // The commit point is only ever a tick boundary.
    assert property (@(posedge clk) disable iff (!rst_n) wrap |-> tick);

    // Zero-extended compare so a full power-of-two bank still works.
    assign wr_in_range = ({1'b0, wr_addr} < AW1'(NUM_CH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_in_range;
        end
    end

    // Both banks update on the same edge: active picks up shadow's value
    // from before any write on the wrap cycle, so such a write waits for
    // the next frame. Out-of-range addresses match no channel here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= DUTY_W'(RESET_DUTY);
                active[i] <= DUTY_W'(RESET_DUTY);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap) begin
                    active[i] <= shadow[i];
                end
                if (wr_en && (wr_addr == AW'(i))) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

    // Readback always shows the shadow bank, i.e. what commits next.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = shadow[i];
            end
        end
    end

    // Threshold is computed at counter width, which is wide enough to hold
    // MIN_PULSE plus the largest duty code without wrapping.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign pwm_next[i] = out_en && (cnt < (CW'(MIN_PULSE) + CW'(active[i])));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_next;
        end
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_servo_pwm_bank
// Self-checking bench: a cycle-level reference model pushes expected outputs
// into a scoreboard at every rising edge, and a checker pops and compares them
// at the following falling edge. Per-frame high-time counts are also checked
// against hand-derived constants for each scenario.
// ---------------------------------------------------------------------------
module tb_servo_pwm_bank;

    localparam int NUM_CH       = 4;
    localparam int DUTY_W       = 3;
    localparam int PRESCALE     = 2;
    localparam int MIN_PULSE    = 4;
    localparam int PERIOD_TICKS = 20;
    localparam int RESET_DUTY   = 4;
    localparam int AW           = 3;
    localparam int FRAME_CYC    = PRESCALE * PERIOD_TICKS;

    typedef struct {
        logic [NUM_CH-1:0] pwm;
        logic              fs;
        logic              err;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DUTY_W-1:0] wr_data;
    logic              wr_err;
    logic [AW-1:0]     rd_addr;
    logic [DUTY_W-1:0] rd_data;
    logic              out_en;
    logic              frame_start;
    logic [NUM_CH-1:0] pwm_out;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    exp_t m_e;
    exp_t c_e;

    int m_cyc = 0;
    int m_shadow [NUM_CH] = '{4, 4, 4, 4};
    int m_active [NUM_CH] = '{4, 4, 4, 4};

    int seg_hi  [NUM_CH] = '{0, 0, 0, 0};
    int last_hi [NUM_CH] = '{0, 0, 0, 0};
    int seg_len  = 0;
    int last_len = 0;

    servo_pwm_bank #(
        .NUM_CH      (NUM_CH),
        .DUTY_W      (DUTY_W),
        .PRESCALE    (PRESCALE),
        .MIN_PULSE   (MIN_PULSE),
        .PERIOD_TICKS(PERIOD_TICKS),
        .RESET_DUTY  (RESET_DUTY),
        .AW          (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_en     (out_en),
        .frame_start(frame_start),
        .pwm_out    (pwm_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model, written in clock cycles rather than ticks: m_cyc is the
    // cycle index within the frame just before each edge, and a channel is high
    // while that index is below (MIN_PULSE + duty) * PRESCALE.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cyc = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_shadow[i] = RESET_DUTY;
                    m_active[i] = RESET_DUTY;
                end
                m_e.pwm = '0;
                m_e.fs  = 1'b0;
                m_e.err = 1'b0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    m_e.pwm[i] = out_en && (m_cyc < PRESCALE * (MIN_PULSE + m_active[i]));
                end
                m_e.fs  = (m_cyc == FRAME_CYC - 1);
                m_e.err = wr_en && (int'(wr_addr) >= NUM_CH);
                if (m_cyc == FRAME_CYC - 1) begin
                    m_active = m_shadow;
                end
                if (wr_en && (int'(wr_addr) < NUM_CH)) begin
                    m_shadow[wr_addr] = int'(wr_data);
                end
                m_cyc = (m_cyc + 1) % FRAME_CYC;
            end
            sb.push_back(m_e);
        end
    end

    // Scoreboard checker: one expected entry per rising edge, compared on the
    // falling edge, plus the combinational readback against the model shadow.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                c_e = sb.pop_front();
                checkOutput("sb_pwm_out", pwm_out, c_e.pwm);
                checkOutput("sb_frame_start", frame_start, c_e.fs);
                checkOutput("sb_wr_err", wr_err, c_e.err);
                checkOutput("sb_rd_data", rd_data,
                            (int'(rd_addr) < NUM_CH) ? m_shadow[rd_addr] : 0);
            end
        end
    end

    // Frame monitor: counts high cycles per channel between frame_start pulses
    // and latches the totals of the frame that just completed.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seg_hi  = '{0, 0, 0, 0};
                seg_len = 0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (pwm_out[i]) seg_hi[i]++;
                end
                seg_len++;
                if (frame_start) begin
                    last_hi  = seg_hi;
                    last_len = seg_len;
                    seg_hi   = '{0, 0, 0, 0};
                    seg_len  = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic [AW-1:0] addr,
                                 input logic [DUTY_W-1:0] data);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic waitFrame();
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
            if (frame_start === 1'b1) seen = 1'b1;
        end
        #1;
        checkOutput("frame_wait", seen, 1);
    endtask

    task automatic checkFrame(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        int exp_hi [NUM_CH] = '{e0, e1, e2, e3};
        checkOutput({tag, "_len"}, last_len, FRAME_CYC);
        for (int i = 0; i < NUM_CH; i++) begin
            checkOutput($sformatf("%s_hi%0d", tag, i), last_hi[i], exp_hi[i]);
        end
    endtask

    // Scenario driver. Inputs change 1 ns after a falling edge; after
    // waitFrame returns, k further falling edges put the counter at frame
    // cycle k for the next rising edge.
    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        out_en  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_pwm", pwm_out, 0);
        checkOutput("reset_fs", frame_start, 0);
        checkOutput("reset_err", wr_err, 0);
        checkOutput("reset_rd0", rd_data, RESET_DUTY);
        #1 rst_n = 1'b1;

        $display("[TB] reset release, default duty");
        waitFrame();
        checkFrame("t1a", 16, 16, 16, 16);
        waitFrame();
        checkFrame("t1b", 16, 16, 16, 16);

        $display("[TB] mid-frame write ch2=7");
        repeat (5) @(negedge clk);
        #1 rd_addr = 3'd2;
        applyStimulus(1'b1, 3'd2, 3'd7);
        checkOutput("t2_rd2", rd_data, 7);
        waitFrame();
        checkFrame("t2_cur", 16, 16, 16, 16);
        waitFrame();
        checkFrame("t2_next", 16, 16, 22, 16);

        $display("[TB] write ch1=0 on the wrap cycle");
        repeat (FRAME_CYC - 1) @(negedge clk);
        #1;
        applyStimulus(1'b1, 3'd1, 3'd0);
        rd_addr = 3'd1;
        #1 checkOutput("t3_rd1", rd_data, 0);
        waitFrame();
        checkFrame("t3_wrap", 16, 16, 22, 16);
        waitFrame();
        checkFrame("t3_next", 16, 8, 22, 16);

        $display("[TB] out-of-range write");
        repeat (3) @(negedge clk);
        #1 rd_addr = 3'd5;
        applyStimulus(1'b1, 3'd5, 3'd3);
        checkOutput("t4_err", wr_err, 1);
        checkOutput("t4_rd5", rd_data, 0);
        @(negedge clk);
        #1 checkOutput("t4_err_clr", wr_err, 0);
        for (int i = 0; i < NUM_CH; i++) begin
            int exp_rd [NUM_CH] = '{4, 0, 7, 4};
            @(negedge clk);
            #1 rd_addr = AW'(i);
            #1 checkOutput($sformatf("t4_rd%0d", i), rd_data, exp_rd[i]);
        end
        waitFrame();
        checkFrame("t4", 16, 8, 22, 16);

        $display("[TB] out_en gating");
        repeat (10) @(negedge clk);
        #1 out_en = 1'b0;
        @(negedge clk);
        checkOutput("t5_off", pwm_out, 0);
        repeat (19) @(negedge clk);
        #1 out_en = 1'b1;
        waitFrame();
        checkFrame("t5a", 10, 8, 10, 10);
        repeat (3) @(negedge clk);
        #1 out_en = 1'b0;
        repeat (3) @(negedge clk);
        #1 out_en = 1'b1;
        waitFrame();
        checkFrame("t5b", 13, 5, 19, 13);

        $display("[TB] reset mid-pulse");
        repeat (2) @(negedge clk);
        #1;
        applyStimulus(1'b1, 3'd0, 3'd7);
        waitFrame();
        checkFrame("t6_pre", 16, 8, 22, 16);
        repeat (4) @(negedge clk);
        #1 checkOutput("t6_midpulse", pwm_out[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_pwm", pwm_out, 0);
        checkOutput("t6_rst_fs", frame_start, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rd_addr = 3'd0;
        #1 checkOutput("t6_rd0", rd_data, RESET_DUTY);
        waitFrame();
        checkFrame("t6_post", 16, 16, 16, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
